// File: rtl/ddr_frame_pkg.sv
// ddr_frame_pkg: shared types and constants for the DDR frame sequencer.
// Optional feature macro: DDR_FRAME_CRC_EN adds the CRC state to the enum.
package ddr_frame_pkg;

  // Slot counter: four slots of two bits each make one byte.
  localparam int                SLOT_W    = 2;
  localparam logic [SLOT_W-1:0] SLOT_LAST = 2'd3;

  // Gap down-counter width, enough for 1..15 idle bytes.
  localparam int GAP_CNT_W = 4;

  // CRC-8 polynomial x^8 + x^2 + x + 1, MSB-first, init 0x00.
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // The CRC encoding only exists when the feature is built in.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
`ifdef DDR_FRAME_CRC_EN
    ST_CRC  = 3'd3,
`endif
    ST_GAP  = 3'd4
  } state_e;

endpackage

// File: rtl/ddr_frame_crc8.sv
// ddr_frame_crc8: combinational CRC-8 update, one full byte per call.
// Used only when DDR_FRAME_CRC_EN is defined.
module ddr_frame_crc8 (
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);
  import ddr_frame_pkg::*;

  logic [7:0] work;

  // Eight shift/XOR steps of a non-reflected CRC with the byte folded in up front.
  always_comb begin
    work = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      if (work[7]) begin
        work = {work[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        work = {work[6:0], 1'b0};
      end
    end
    crc_o = work;
  end

endmodule

// File: rtl/ddr_frame_sequencer.sv
// ddr_frame_sequencer: frames a byte stream as SYNC, payload, optional CRC and an
// idle gap, and serialises it two bits per clock onto a DDR pin pair, LSB first.
// Optional feature macro: DDR_FRAME_CRC_EN appends a CRC-8 byte after the payload.
//
// state | meaning
// IDLE  | line fill with IDLE_BYTE, waiting for s_valid at a byte boundary
// SYNC  | SYNC_BYTE sent, then IDLE_BYTE fillers until the first payload byte arrives
// DATA  | payload bytes, next byte handshaked at slot 3
// CRC   | CRC-8 of the accepted payload (DDR_FRAME_CRC_EN builds only)
// GAP   | GAP_BYTES idle bytes, s_valid ignored
module ddr_frame_sequencer #(
  parameter logic [7:0] SYNC_BYTE = 8'hD5,
  parameter logic [7:0] IDLE_BYTE = 8'h55,
  parameter int         GAP_BYTES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       d_out_0,
  output logic       d_out_1,
  output logic       busy,
  output logic       err_underrun
);
  import ddr_frame_pkg::*;

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_BYTES - 1);

  state_e               state_q, state_d;
  logic [SLOT_W-1:0]    slot_q;
  logic [7:0]           shift_q, shift_d;
  logic                 last_q, last_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic                 dout0_q, dout1_q;
  logic                 boundary;
  logic                 accept;

  assign boundary = (slot_q == SLOT_LAST);
  assign accept   = s_valid & s_ready;
  assign busy     = (state_q != ST_IDLE);
  assign d_out_0  = dout0_q;
  assign d_out_1  = dout1_q;

`ifdef DDR_FRAME_CRC_EN
  logic [7:0] crc_q, crc_d, crc_next;

  ddr_frame_crc8 u_crc8 (
    .crc_i  (crc_q),
    .data_i (s_data),
    .crc_o  (crc_next)
  );

  // Running CRC over accepted payload bytes; IDLE clears it between frames.
  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_IDLE) begin
      crc_d = 8'h00;
    end else if (accept) begin
      crc_d = crc_next;
    end
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

  // Free-running slot counter; byte boundaries stay locked to reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

  // Pin registers: the dibit of the current slot appears one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout0_q <= 1'b0;
      dout1_q <= 1'b0;
    end else begin
      dout0_q <= shift_q[{slot_q, 1'b0}];
      dout1_q <= shift_q[{slot_q, 1'b1}];
    end
  end

  // State, outgoing byte, last-byte flag and gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= IDLE_BYTE;
      last_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state and next-byte selection; every decision waits for slot 3 so a
  // byte is never cut short. The handshake outputs are combinational so the
  // source sees s_ready in the same cycle the byte is loaded.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    last_d       = last_q;
    gap_d        = gap_q;
    s_ready      = 1'b0;
    err_underrun = 1'b0;
    if (boundary) begin
      case (state_q)
        ST_IDLE: begin
          shift_d = IDLE_BYTE;
          if (s_valid) begin
            state_d = ST_SYNC;
            shift_d = SYNC_BYTE;
          end
        end
        ST_SYNC: begin
          s_ready = 1'b1;
          if (s_valid) begin
            state_d = ST_DATA;
            shift_d = s_data;
            last_d  = s_last;
          end else begin
            shift_d = IDLE_BYTE;
          end
        end
        ST_DATA: begin
          if (!last_q) begin
            s_ready = 1'b1;
            if (s_valid) begin
              shift_d = s_data;
              last_d  = s_last;
            end else begin
              // Source starved mid-frame: the frame is abandoned, no CRC.
              err_underrun = 1'b1;
              state_d      = ST_GAP;
              shift_d      = IDLE_BYTE;
              gap_d        = GAP_LOAD;
            end
          end else begin
`ifdef DDR_FRAME_CRC_EN
            // crc_q already includes the last byte, folded in when it was accepted.
            state_d = ST_CRC;
            shift_d = crc_q;
`else
            state_d = ST_GAP;
            shift_d = IDLE_BYTE;
            gap_d   = GAP_LOAD;
`endif
          end
        end
`ifdef DDR_FRAME_CRC_EN
        ST_CRC: begin
          state_d = ST_GAP;
          shift_d = IDLE_BYTE;
          gap_d   = GAP_LOAD;
        end
`endif
        ST_GAP: begin
          shift_d = IDLE_BYTE;
          if (gap_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - GAP_CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          shift_d = IDLE_BYTE;
        end
      endcase
    end
  end

endmodule
